// File: rtl/data_producer.sv
// data_producer: dummy AXI-Stream source. A start pulse emits packet_count
// fixed-length packets carrying an incrementing 32-bit word sequence, with
// optional TVALID throttle bubbles and inter-packet gaps.

// One 32-bit lane of the word pattern: current beat value and the value the
// same lane takes on the following beat.
module dp_lane #(
  parameter int LANE  = 0,
  parameter int NLANE = 1
) (
  input  logic [31:0] seq,
  output logic [31:0] cur,
  output logic [31:0] nxt
);
  assign cur = seq + 32'(LANE);
  assign nxt = seq + 32'(NLANE + LANE);
endmodule

module data_producer #(
  parameter int          DW            = 32,
  parameter int          PACKET_BEATS  = 16,
  parameter int          VALID_CYCLES  = 0,
  parameter int          NVALID_CYCLES = 0,
  parameter int          IDLE_CYCLES   = 0,
  // Reset value of the sequence counter; lets a bench start near the wrap.
  parameter logic [31:0] SEQ_INIT      = 32'h0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [15:0]     packet_count,
  output logic            busy,
  output logic            done,
  output logic [DW-1:0]   AXIS_TX_TDATA,
  output logic [DW/8-1:0] AXIS_TX_TKEEP,
  output logic            AXIS_TX_TUSER,
  output logic            AXIS_TX_TLAST,
  output logic            AXIS_TX_TVALID,
  input  logic            AXIS_TX_TREADY
);
  localparam int NLANE = DW / 32;
  localparam int BW    = (PACKET_BEATS < 2) ? 1 : $clog2(PACKET_BEATS);
  localparam int CMAX0 = (VALID_CYCLES > NVALID_CYCLES) ? VALID_CYCLES : NVALID_CYCLES;
  localparam int CMAX  = (CMAX0 > IDLE_CYCLES) ? CMAX0 : IDLE_CYCLES;
  localparam int CW    = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
  localparam bit THR_EN    = (VALID_CYCLES != 0) && (NVALID_CYCLES != 0);
  localparam bit GAP_EN    = (IDLE_CYCLES != 0);
  localparam bit ONE_BEAT  = (PACKET_BEATS == 1);

  localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_BEATS - 1);
  localparam logic [CW-1:0] VC        = CW'(VALID_CYCLES);
  localparam logic [CW-1:0] NV_LAST   = CW'(NVALID_CYCLES - 1);
  localparam logic [CW-1:0] IG_LAST   = CW'(IDLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, THROTTLE, GAP} state_t;

  state_t                        state;
  logic [31:0]                   seq;
  logic [15:0]                   remaining;
  logic [BW-1:0]                 beat;
  logic [CW-1:0]                 cnt;
  logic [NLANE-1:0][31:0]        tdata_q;
  logic [NLANE-1:0][31:0]        lane_cur, lane_nxt;
  logic                          accept;

  // Per-lane word values for the current and next beat.
  for (genvar g = 0; g < NLANE; g++) begin : g_lane
    dp_lane #(.LANE(g), .NLANE(NLANE)) u_lane (
      .seq (seq),
      .cur (lane_cur[g]),
      .nxt (lane_nxt[g])
    );
  end

  assign accept         = AXIS_TX_TVALID & AXIS_TX_TREADY;
  assign AXIS_TX_TDATA  = tdata_q;
  assign AXIS_TX_TKEEP  = '1;

  // Control FSM; every stream output is registered here so nothing depends
  // combinationally on TREADY. cnt serves both as throttle beat count and as
  // bubble/gap length counter, since those uses never overlap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      seq            <= SEQ_INIT;
      remaining      <= '0;
      beat           <= '0;
      cnt            <= '0;
      tdata_q        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      AXIS_TX_TVALID <= 1'b0;
      AXIS_TX_TUSER  <= 1'b0;
      AXIS_TX_TLAST  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // done high means the run ended at the last edge: treat as busy.
          if (start && !done && packet_count != 16'd0) begin
            remaining      <= packet_count;
            beat           <= '0;
            cnt            <= '0;
            busy           <= 1'b1;
            state          <= SEND;
            AXIS_TX_TVALID <= 1'b1;
            AXIS_TX_TUSER  <= 1'b1;
            AXIS_TX_TLAST  <= ONE_BEAT;
            tdata_q        <= lane_cur;
          end
        end
        SEND: begin
          if (accept) begin
            seq     <= seq + 32'(NLANE);
            tdata_q <= lane_nxt;
            if (beat == LAST_BEAT) begin
              beat <= '0;
              cnt  <= '0;
              if (remaining == 16'd1) begin
                state          <= IDLE;
                done           <= 1'b1;
                busy           <= 1'b0;
                AXIS_TX_TVALID <= 1'b0;
                AXIS_TX_TUSER  <= 1'b0;
                AXIS_TX_TLAST  <= 1'b0;
              end else begin
                remaining     <= remaining - 16'd1;
                AXIS_TX_TUSER <= 1'b1;
                AXIS_TX_TLAST <= ONE_BEAT;
                if (GAP_EN) begin
                  state          <= GAP;
                  AXIS_TX_TVALID <= 1'b0;
                end
              end
            end else begin
              beat          <= beat + 1'b1;
              AXIS_TX_TUSER <= 1'b0;
              AXIS_TX_TLAST <= (beat + 1'b1 == LAST_BEAT);
              if (THR_EN && (cnt + 1'b1 == VC)) begin
                cnt            <= '0;
                state          <= THROTTLE;
                AXIS_TX_TVALID <= 1'b0;
              end else if (THR_EN) begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end
        THROTTLE: begin
          if (cnt == NV_LAST) begin
            cnt            <= '0;
            state          <= SEND;
            AXIS_TX_TVALID <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == IG_LAST) begin
            cnt            <= '0;
            state          <= SEND;
            AXIS_TX_TVALID <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_producer.sv
// tb_data_producer: three producer instances (default, throttled with a
// sequence preset near wrap, 64-bit with inter-packet gap) checked against a
// packet-level reference model through per-instance scoreboards.
module tb_data_producer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]  start = '0, busy, done, tuser, tlast, tvalid;
  logic [2:0]  tready = '1;
  logic [15:0] pkt [3];
  logic [31:0] d0, d1;
  logic [63:0] d2;
  logic [3:0]  k0, k1;
  logic [7:0]  k2;
  bit   [2:0]  rmode = '0;

  data_producer u0 (
    .clk(clk), .resetn(resetn), .start(start[0]), .packet_count(pkt[0]),
    .busy(busy[0]), .done(done[0]), .AXIS_TX_TDATA(d0), .AXIS_TX_TKEEP(k0),
    .AXIS_TX_TUSER(tuser[0]), .AXIS_TX_TLAST(tlast[0]),
    .AXIS_TX_TVALID(tvalid[0]), .AXIS_TX_TREADY(tready[0]));

  data_producer #(.PACKET_BEATS(10), .VALID_CYCLES(4), .NVALID_CYCLES(2),
                  .SEQ_INIT(32'hFFFF_FFF0)) u1 (
    .clk(clk), .resetn(resetn), .start(start[1]), .packet_count(pkt[1]),
    .busy(busy[1]), .done(done[1]), .AXIS_TX_TDATA(d1), .AXIS_TX_TKEEP(k1),
    .AXIS_TX_TUSER(tuser[1]), .AXIS_TX_TLAST(tlast[1]),
    .AXIS_TX_TVALID(tvalid[1]), .AXIS_TX_TREADY(tready[1]));

  data_producer #(.DW(64), .IDLE_CYCLES(3)) u2 (
    .clk(clk), .resetn(resetn), .start(start[2]), .packet_count(pkt[2]),
    .busy(busy[2]), .done(done[2]), .AXIS_TX_TDATA(d2), .AXIS_TX_TKEEP(k2),
    .AXIS_TX_TUSER(tuser[2]), .AXIS_TX_TLAST(tlast[2]),
    .AXIS_TX_TVALID(tvalid[2]), .AXIS_TX_TREADY(tready[2]));

  // Instance configurations as seen by the reference model.
  int          LANES [3] = '{1, 1, 2};
  int          PB    [3] = '{16, 10, 16};
  int          VC    [3] = '{0, 4, 0};
  int          NV    [3] = '{0, 2, 0};
  int          IG    [3] = '{0, 0, 3};
  int unsigned SINIT [3] = '{32'h0, 32'hFFFF_FFF0, 32'h0};

  typedef struct {
    logic [63:0] data;
    bit          user;
    bit          last;
    bit          fin;
    int          cyc;
  } exp_t;

  exp_t        sbq [3][$];
  int unsigned mseq [3];
  int          ncmp = 0, nbad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] getd(input int i);
    case (i)
      0:       return {32'h0, d0};
      1:       return {32'h0, d1};
      default: return d2;
    endcase
  endfunction

  // Reference model: expand a run into its beats. With TREADY held high the
  // cycle of each beat follows from the packet layout: within a packet a
  // bubble of NV cycles follows every VC-th beat except the last, and a gap
  // of IG cycles separates packets.
  task automatic push_run(input int i, input int n, input int s, input bit timed);
    bit   th   = (VC[i] != 0) && (NV[i] != 0);
    int   plen = PB[i] + (th ? NV[i] * ((PB[i] - 1) / VC[i]) : 0) + IG[i];
    exp_t e;
    for (int p = 0; p < n; p++)
      for (int k = 0; k < PB[i]; k++) begin
        e.data = (LANES[i] == 2) ? {mseq[i] + 32'd1, mseq[i]} : {32'h0, mseq[i]};
        mseq[i] += LANES[i];
        e.user = (k == 0);
        e.last = (k == PB[i] - 1);
        e.fin  = e.last && (p == n - 1);
        e.cyc  = timed ? s + 1 + p * plen + k + (th ? NV[i] * (k / VC[i]) : 0) : -1;
        sbq[i].push_back(e);
      end
  endtask

  // TREADY: held high, or random per cycle when the instance is in stall mode.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++)
      tready[i] = rmode[i] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: beats seen valid&ready at the falling edge are accepted at the
  // next rising edge; they are popped and compared here.
  bit          stall [3];
  bit          pend  [3];
  logic [63:0] hd    [3];
  logic [1:0]  hul   [3];
  always @(negedge clk) begin
    logic [63:0] d;
    exp_t        e;
    bit          ed;
    if (!resetn) begin
      for (int i = 0; i < 3; i++) begin
        sbq[i].delete();
        pend[i]  = 1'b0;
        stall[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        d  = getd(i);
        ed = pend[i];
        pend[i] = 1'b0;
        if (done[i] || ed) begin
          chk($sformatf("done%0d", i), 64'(done[i]), 64'(ed));
          if (ed) chk($sformatf("busy_at_done%0d", i), 64'(busy[i]), 64'd0);
        end
        if (stall[i]) begin
          chk($sformatf("hold_valid%0d", i), 64'(tvalid[i]), 64'd1);
          chk($sformatf("hold_data%0d", i), d, hd[i]);
          chk($sformatf("hold_user_last%0d", i), 64'({tuser[i], tlast[i]}), 64'(hul[i]));
        end
        if (tvalid[i] && tready[i]) begin
          if (sbq[i].size() == 0) begin
            ncmp++; nbad++;
            $display("FAIL extra_beat%0d: got data %0h expected no beat", i, d);
          end else begin
            e = sbq[i].pop_front();
            chk($sformatf("data%0d", i), d, e.data);
            chk($sformatf("tuser%0d", i), 64'(tuser[i]), 64'(e.user));
            chk($sformatf("tlast%0d", i), 64'(tlast[i]), 64'(e.last));
            if (e.cyc >= 0) chk($sformatf("beat_cycle%0d", i), 64'(cyc), 64'(e.cyc));
            pend[i] = e.fin;
          end
        end
        stall[i] = tvalid[i] && !tready[i];
        hd[i]    = d;
        hul[i]   = {tuser[i], tlast[i]};
      end
    end
  end

  task automatic do_start(input int i, input int n, input bit accepted);
    @(posedge clk); #2;
    start[i] = 1'b1;
    pkt[i]   = 16'(n);
    if (accepted && n != 0) push_run(i, n, cyc, rmode[i] == 1'b0);
    @(posedge clk); #2;
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int t = 0;
    while ((sbq[i].size() != 0 || busy[i]) && t < budget) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    if (t >= budget) begin
      ncmp++; nbad++;
      $display("FAIL run_timeout%0d: got %0d beats left expected 0", i, sbq[i].size());
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pkt[i]  = '0;
      mseq[i] = SINIT[i];
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tvalid%0d", i), 64'(tvalid[i]), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy[i]), 64'd0);
      chk($sformatf("rst_done%0d", i), 64'(done[i]), 64'd0);
      chk($sformatf("rst_user_last%0d", i), 64'({tuser[i], tlast[i]}), 64'd0);
      chk($sformatf("rst_tdata%0d", i), getd(i), 64'd0);
    end
    chk("rst_tkeep0", 64'(k0), 64'hF);
    chk("rst_tkeep2", 64'(k2), 64'hFF);
    @(negedge clk) resetn = 1'b1;

    // Two default packets at full rate, then a start issued mid-run.
    do_start(0, 2, 1'b1);
    wait_idle(0, 200);
    do_start(0, 2, 1'b1);
    repeat (5) @(posedge clk);
    do_start(0, 5, 1'b0);
    wait_idle(0, 200);

    // Back-pressure: three packets under random TREADY.
    rmode[0] = 1'b1;
    do_start(0, 3, 1'b1);
    wait_idle(0, 2000);
    rmode[0] = 1'b0;

    // Throttle pattern, crossing the 32-bit sequence wrap.
    do_start(1, 2, 1'b1);
    wait_idle(1, 200);

    // 64-bit bus with inter-packet gap; second run continues the sequence.
    do_start(2, 2, 1'b1);
    wait_idle(2, 200);
    do_start(2, 1, 1'b1);
    wait_idle(2, 200);

    // packet_count of zero is ignored.
    do_start(0, 0, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("zero_cnt_busy", 64'(busy[0]), 64'd0);
      chk("zero_cnt_valid", 64'(tvalid[0]), 64'd0);
    end

    // Random runs on random instances, with and without stalls.
    for (int r = 0; r < 6; r++) begin
      int i = int'($urandom_range(0, 2));
      rmode[i] = 1'($urandom_range(0, 1));
      do_start(i, int'($urandom_range(1, 3)), 1'b1);
      wait_idle(i, 3000);
      rmode[i] = 1'b0;
    end

    // Asynchronous reset in the middle of a packet.
    do_start(0, 2, 1'b1);
    repeat (7) @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(tvalid[0]), 64'd0);
    chk("async_rst_busy", 64'(busy[0]), 64'd0);
    chk("async_rst_done", 64'(done[0]), 64'd0);
    chk("async_rst_tdata", getd(0), 64'd0);
    for (int i = 0; i < 3; i++) mseq[i] = SINIT[i];
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b1;
    do_start(0, 1, 1'b1);
    wait_idle(0, 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
